approx_mult_seq: RTL and testbench
==================================

# approx_mult_seq

Parametrised, iterative unsigned multiplier built on the half-adder/full-adder datapath of the approximate multiplier family. It adds a configurable lower-part-OR approximation and a per-operation exact/approximate mode select. It uses a valid/ready handshake at input and output, so it can sit between streaming operand sources and accumulator stages. Each accepted operation retires one multiplier bit per cycle.

## Interface
- WIDTH, 16: operand width in bits; product is 2*WIDTH bits; legal range 2..32.
- APPROX_BITS, 8: number of low product columns computed with OR instead of addition in approximate mode; legal range 0..WIDTH; 0 gives exact results in both modes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- approx_en  in  1  1 = approximate add for this operation, 0 = exact.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2*WIDTH  product.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b, approx_en; clear accumulator; set cnt=0; go to BUSY.
  - BUSY: in_ready=0. Each cycle processes multiplier bit cnt:
    - pp = b_lat[cnt] ? (a_lat << cnt) : 0, zero-extended to 2*WIDTH.
    - acc <= add(acc, pp); cnt <= cnt+1.
    - After processing bit WIDTH-1, go to DONE.
  - DONE: out_valid=1; p holds acc. On out_ready go to IDLE. in_ready=0 in DONE, so no overlap of accept and retire.
- Exact add(x,y): x+y, truncated to 2*WIDTH bits.
- Approximate add(x,y), K=APPROX_BITS>0:
  - Low field [K-1:0] = x | y.
  - Carry-in to the high field, cin = x[K-1] & y[K-1].
  - High field [2W-1:K] = x[2W-1:K] + y[2W-1:K] + cin, truncated.
- approx_en is sampled only at acceptance. Changes during BUSY or DONE have no effect.
- a, b are sampled only at acceptance. Input changes while not in IDLE are ignored.
- p is registered. It is stable from the start of DONE until handshake completion, and holds its last value in IDLE.
- Reset, asynchronous at any time including mid-BUSY or DONE:
  - state=IDLE, cnt=0, acc=0, p=0, out_valid=0, in_ready=1 (no reset-time stall), latched operands=0.
  - Any in-flight operation is discarded and no output is produced.

## Timing
- Acceptance on edge T0. BUSY spans the WIDTH edges T1..TWIDTH. out_valid rises after edge TWIDTH, i.e. WIDTH cycles after acceptance.
- out_valid falls on the edge where out_valid&out_ready is sampled high.
- in_ready rises on that same edge; the next acceptance is possible one cycle later.
- Minimum throughput: one operation per WIDTH+2 cycles.
- out_ready held low: DONE persists indefinitely with p and out_valid stable.
- out_ready held high: DONE lasts exactly one cycle.
- in_valid asserted outside IDLE: ignored, no acceptance. The source must hold in_valid until in_ready.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
- Exact, defaults: a=0xFFFF, b=0xFFFF, approx_en=0 -> p=0xFFFE0001, out_valid exactly 16 cycles after acceptance.
- Approximate, defaults (K=8): a=3, b=3, approx_en=1 -> p=0x00000007. Same operands with approx_en=0 -> p=0x00000009.
- APPROX_BITS=2 build, a=3, b=3, approx_en=1 -> p=0x0000000B. APPROX_BITS=0 build, a=0x1234, b=0x5678, approx_en=1 -> p=0x06260060 (exact).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, toggling a, b, in_valid meanwhile -> p and out_valid stable, in_ready=0. Raise out_ready -> one-cycle handshake, then in_ready=1.
- Reset mid-operation: assert rst_n=0 at cnt=5, release, then issue a=7, b=6, approx_en=0 -> out_valid=0 and p=0 during and after reset; next result p=42 with no stale output.
- Zero and mode latch: a=0xABCD, b=0, approx_en=1, toggle approx_en during BUSY -> p=0. Random 1000-vector run checked against a bit-true reference model in both modes.

Source files
------------

// File: rtl/approx_mult_seq.sv
// approx_mult_seq
// Iterative unsigned shift-and-add multiplier with an optional lower-part-OR
// approximation. One multiplier bit is retired per cycle. The mode
// (exact / approximate) is chosen per operation at acceptance.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on the state register (high in IDLE).
// out_valid depends only on the state register (high in DONE). Neither
// depends combinationally on in_valid or out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE)
//   a          multiplicand, unsigned, WIDTH bits
//   b          multiplier, unsigned, WIDTH bits
//   approx_en  1 = approximate add for this operation, 0 = exact
//   out_valid  product valid (DONE)
//   out_ready  consumer accepts product
//   p          registered product, 2*WIDTH bits
module approx_mult_seq #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW   = 2 * WIDTH;
  localparam int CW   = $clog2(WIDTH);
  // Column that feeds the carry into the high field; unused when K=0.
  localparam int KIDX = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
  localparam logic [PW-1:0] LOW_MASK =
    (APPROX_BITS == 0) ? '0 : ({PW{1'b1}} >> (PW - APPROX_BITS));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic            approx_q, approx_d;
  logic [PW-1:0]   p_q, p_d;

  logic [PW-1:0]   pp;
  logic [PW-1:0]   sum;
  logic            last_bit;
  logic            accept;

  // Exact add, or: low K columns ORed, high field added with a carry-in
  // generated from the top low column (x[K-1] & y[K-1]).
  function automatic logic [PW-1:0] add_fn(input logic [PW-1:0] x,
                                           input logic [PW-1:0] y,
                                           input logic          approx);
    logic [PW-1:0] xh;
    logic [PW-1:0] yh;
    logic [PW-1:0] hi;
    logic          cin;
    if (!approx || APPROX_BITS == 0) begin
      add_fn = x + y;
    end else begin
      xh     = x >> APPROX_BITS;
      yh     = y >> APPROX_BITS;
      cin    = x[KIDX] & y[KIDX];
      hi     = xh + yh + {{(PW-1){1'b0}}, cin};
      add_fn = (hi << APPROX_BITS) | ((x | y) & LOW_MASK);
    end
  endfunction

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)  state_d = S_BUSY;
      S_BUSY: if (last_bit)  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    pp       = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    sum      = add_fn(acc_q, pp, approx_q);
    if (accept) begin
      a_d      = a;
      b_d      = b;
      approx_d = approx_en;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == S_BUSY) begin
      acc_d = sum;
      cnt_d = cnt_q + CW'(1);
      // p is loaded with the final sum so it is valid on the first DONE cycle
      // and holds until the next operation completes.
      if (last_bit) p_d = sum;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    p         = p_q;
  end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Bench for approx_mult_seq: three builds (APPROX_BITS = 8, 2, 0) driven in
// lock step from shared stimulus; expected products queued at acceptance and
// popped at the output handshake.
module tb_approx_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        approx_en;
  logic        out_ready;

  logic        in_ready8, in_ready2, in_ready0;
  logic        out_valid8, out_valid2, out_valid0;
  logic [31:0] p8, p2, p0;

  logic [31:0] exp8_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] exp0_q[$];

  int total;
  int bad;

  approx_mult_seq #(.WIDTH(16), .APPROX_BITS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid8),
    .out_ready(out_ready), .p(p8)
  );

  approx_mult_seq #(.WIDTH(16), .APPROX_BITS(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid2),
    .out_ready(out_ready), .p(p2)
  );

  approx_mult_seq #(.WIDTH(16), .APPROX_BITS(0)) u_k0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid0),
    .out_ready(out_ready), .p(p0)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Bit-level reference: ripple adder over columns, OR in the low kk columns.
  function automatic logic [31:0] m_add(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic ae, input int k);
    logic [31:0] r;
    logic        c;
    int          kk;
    kk = ae ? k : 0;
    c  = 1'b0;
    r  = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < kk) begin
        r[i] = x[i] | y[i];
      end else begin
        if (i == kk && kk > 0) c = x[kk-1] & y[kk-1];
        r[i] = x[i] ^ y[i] ^ c;
        c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] m_mul(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic ae, input int k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++)
      if (y[i]) acc = m_add(acc, {16'h0, x} << i, ae, k);
    return acc;
  endfunction

  task automatic pop_chk(input string name, input logic [31:0] obs,
                         inout logic [31:0] q[$]);
    logic [31:0] e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=<empty queue>", name, obs);
    end else begin
      e = q.pop_front();
      chk(name, {32'h0, obs}, {32'h0, e});
    end
  endtask

  // Driver: one full operation with optional backpressure and input toggling.
  task automatic run_op(input logic [15:0] aa, input logic [15:0] bb,
                        input logic ae, input int bp, input bit tog,
                        input logic [31:0] e8, input logic [31:0] e2,
                        input logic [31:0] e0);
    int n;
    @(negedge clk);
    chk("in_ready_idle", {63'h0, in_ready8}, 64'h1);
    a         = aa;
    b         = bb;
    approx_en = ae;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp8_q.push_back(e8);
    exp2_q.push_back(e2);
    exp0_q.push_back(e0);
    n = 0;
    while (!out_valid8 && n < 100) begin
      if (tog) begin
        approx_en = ~approx_en;
        a         = 16'($urandom_range(0, 16'hFFFF));
        b         = 16'($urandom_range(0, 16'hFFFF));
        in_valid  = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(n), 64'd16);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {63'h0, out_valid8}, 64'h1);
      chk("bp_in_ready", {63'h0, in_ready8}, 64'h0);
      chk("bp_p_stable", {32'h0, p8}, {32'h0, exp8_q[0]});
      a        = 16'($urandom_range(0, 16'hFFFF));
      b        = 16'($urandom_range(0, 16'hFFFF));
      in_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("out_valid_k2", {63'h0, out_valid2}, 64'h1);
    chk("out_valid_k0", {63'h0, out_valid0}, 64'h1);
    pop_chk("p_k8", p8, exp8_q);
    pop_chk("p_k2", p2, exp2_q);
    pop_chk("p_k0", p0, exp0_q);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", {63'h0, out_valid8}, 64'h0);
    chk("in_ready_rise", {63'h0, in_ready8}, 64'h1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        re;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    approx_en = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'h0, in_ready8}, 64'h1);
    chk("rst_out_valid", {63'h0, out_valid8}, 64'h0);
    chk("rst_p", {32'h0, p8}, 64'h0);
    rst_n = 1'b1;

    // Exact full-scale, with backpressure and input toggling while busy/done
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 10, 1'b1,
           32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    // Lower-part OR at small operands
    run_op(16'h0003, 16'h0003, 1'b1, 0, 1'b0, 32'h7, 32'hB, 32'h9);
    run_op(16'h0003, 16'h0003, 1'b0, 0, 1'b0, 32'h9, 32'h9, 32'h9);
    run_op(16'h1234, 16'h5678, 1'b1, 2, 1'b0,
           m_mul(16'h1234, 16'h5678, 1'b1, 8),
           m_mul(16'h1234, 16'h5678, 1'b1, 2), 32'h06260060);
    // Zero multiplier, mode toggled during BUSY
    run_op(16'hABCD, 16'h0000, 1'b1, 0, 1'b1, 32'h0, 32'h0, 32'h0);

    // Reset mid-operation at cnt=5
    @(negedge clk);
    a         = 16'h1234;
    b         = 16'h5678;
    approx_en = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'h0, out_valid8}, 64'h0);
    chk("midrst_in_ready", {63'h0, in_ready8}, 64'h1);
    chk("midrst_p", {32'h0, p8}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("postrst_out_valid", {63'h0, out_valid8}, 64'h0);
      chk("postrst_p", {32'h0, p8}, 64'h0);
    end
    run_op(16'd7, 16'd6, 1'b0, 0, 1'b0, 32'd42, 32'd42, 32'd42);

    // Random vectors in both modes against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      re = 1'($urandom_range(0, 1));
      run_op(ra, rb, re, 0, 1'b0,
             m_mul(ra, rb, re, 8), m_mul(ra, rb, re, 2), m_mul(ra, rb, re, 0));
    end

    chk("queue_empty", 64'(exp8_q.size() + exp2_q.size() + exp0_q.size()),
        64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
